// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
//
// Instruction-memory bus between the fetch unit and instruction memory.
// Requests use a valid/ready handshake; responses come back in request order
// and cannot be back-pressured.
//
// Signals:
//   imem_req_valid  fetch request valid               (fetch unit -> memory)
//   imem_req_ready  memory accepts the request         (memory -> fetch unit)
//   imem_addr       word-aligned fetch address         (fetch unit -> memory)
//   imem_rsp_valid  response word valid                (memory -> fetch unit)
//   imem_rsp_data   returned instruction word          (memory -> fetch unit)
//
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the MIPS pipeline. Owns the PC, issues in-order fetch requests
// to instruction memory, buffers returned words in a prefetch FIFO and feeds
// the decode register {Instruction_D, PC_D, valid_D}. A redirect flushes all
// younger fetched state and discards every response still in flight.
//
// Parameters:
//   RESET_PC  first PC fetched after reset
//   DEPTH     prefetch capacity (outstanding requests + FIFO entries),
//             power of two, >= 2
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem            instruction-memory bus (master modport)
//   stall_D         decode holds its input register
//   redirect_valid  load redirect_pc (word aligned) and flush
//   redirect_pc     redirect target, bits [1:0] ignored
//   Instruction_D   instruction to decode (0 = NOP after reset/redirect)
//   PC_D            PC of Instruction_D
//   valid_D         Instruction_D/PC_D valid
//
// Optional feature, enabled by defining IFU_PERF_CNT_EN:
//   perf_fetch_cnt  count of decode-register loads
//   perf_bubble_cnt count of unstalled, non-redirect cycles with an empty FIFO
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master imem,
  input  logic                     stall_D,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              Instruction_D,
  output logic [31:0]              PC_D,
  output logic                     valid_D
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetch_cnt,
  output logic [31:0]              perf_bubble_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] drop;
  logic [CW:0]   credit_used;

  // PC of every outstanding request, in issue order
  logic [31:0]   tag_mem [DEPTH];
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;

  // Prefetch FIFO of {pc, word}
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] fifo_rd;

  logic accept;
  logic rsp_fire;
  logic rsp_keep;
  logic fifo_empty;
  logic pop;
  logic bypass;
  logic push;

  // Credits cover both in-flight requests and buffered words, so a returning
  // response always finds room in the FIFO. A redirect cycle never issues,
  // which is why the redirect can compute the drop count without an accept.
  always_comb begin
    credit_used         = {1'b0, outstanding} + {1'b0, fifo_count};
    imem.imem_req_valid = !rst && (credit_used < DEPTH_W) && !redirect_valid;
    imem.imem_addr      = pc;
    accept              = imem.imem_req_valid && imem.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored
    rsp_fire            = imem.imem_rsp_valid && (outstanding != '0);
    rsp_keep            = rsp_fire && (drop == '0) && !redirect_valid;
    fifo_empty          = (fifo_count == '0);
    pop                 = !redirect_valid && !stall_D && !fifo_empty;
    // An empty FIFO lets a response go straight into the decode register
    bypass              = !redirect_valid && !stall_D && fifo_empty && rsp_keep;
    push                = rsp_keep && !bypass;
  end

  // Tag queue and FIFO storage; pointers live in the control block below
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[tag_wr] <= pc;
    end
    if (push) begin
      fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
      fifo_data[fifo_wr] <= imem.imem_rsp_data;
    end
  end

  // PC, credit counters, FIFO pointers and the decode register. Redirect wins
  // over stall and turns every response still in flight into a drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      outstanding   <= '0;
      fifo_count    <= '0;
      drop          <= '0;
      tag_wr        <= '0;
      tag_rd        <= '0;
      fifo_wr       <= '0;
      fifo_rd       <= '0;
      valid_D       <= 1'b0;
      Instruction_D <= 32'h0;
      PC_D          <= 32'h0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp_fire);
      if (accept) begin
        pc     <= pc + 32'd4;
        tag_wr <= tag_wr + 1'b1;
      end
      if (rsp_fire) begin
        tag_rd <= tag_rd + 1'b1;
      end
      if (redirect_valid) begin
        pc            <= redirect_pc & ~32'h3;
        drop          <= outstanding - CW'(rsp_fire);
        fifo_count    <= '0;
        fifo_wr       <= '0;
        fifo_rd       <= '0;
        valid_D       <= 1'b0;
        Instruction_D <= 32'h0;
        PC_D          <= 32'h0;
      end else begin
        if (rsp_fire && (drop != '0)) begin
          drop <= drop - 1'b1;
        end
        if (push) begin
          fifo_wr <= fifo_wr + 1'b1;
        end
        if (pop) begin
          fifo_rd <= fifo_rd + 1'b1;
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (pop) begin
          valid_D       <= 1'b1;
          Instruction_D <= fifo_data[fifo_rd];
          PC_D          <= fifo_pc[fifo_rd];
        end else if (bypass) begin
          valid_D       <= 1'b1;
          Instruction_D <= imem.imem_rsp_data;
          PC_D          <= tag_mem[tag_rd];
        end else if (!stall_D) begin
          valid_D <= 1'b0;
        end
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Performance counters survive redirects; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= 32'h0;
      perf_bubble_cnt <= 32'h0;
    end else begin
      if (pop || bypass) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (!stall_D && fifo_empty && !redirect_valid) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Memory must never answer a request that was not issued
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem.imem_rsp_valid && (outstanding == '0)));
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Self-checking bench for instruction_fetch_unit. An in-order memory model
// answers the DUT's real requests after a per-request latency. A reference
// model tracks the program-order PC, the words available to decode and which
// in-flight requests a redirect has made stale, and predicts the request
// handshake and the decode register every cycle. Directed scenarios are
// followed by a long randomized run. Perf counters are checked when
// IFU_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mem_req_t;

  logic        clk;
  logic        rst;
  logic        stall_D;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] Instruction_D;
  logic [31:0] PC_D;
  logic        valid_D;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus),
    .stall_D        (stall_D),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .Instruction_D  (Instruction_D),
    .PC_D           (PC_D),
    .valid_D        (valid_D)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_checks = 0;
  int bad_checks   = 0;

  // Memory model and reference model state
  mem_req_t    mem_q [$];
  logic [31:0] avail_pc [$];
  logic [31:0] avail_data [$];
  logic [31:0] m_pc;
  logic        exp_valid;
  logic [31:0] exp_instr;
  logic [31:0] exp_pcd;
  bit          know_instr;
  bit          know_pcd;
  logic [31:0] m_fetch;
  logic [31:0] m_bubble;
  int          cyc      = 0;
  int          last_due = 0;
  int          acc_cnt  = 0;
  logic        seen_req;
  logic [31:0] seen_addr;

  // Instruction word stored at a given address
  function automatic logic [31:0] data_of(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check the request side,
  // advance the models, then check the decode register after the rising edge.
  task automatic applyStimulus(input logic r, input logic st, input logic rd,
                               input logic [31:0] rpc, input logic rdy, input int lat);
    logic     rsp_now;
    logic     m_req;
    logic     m_bub;
    mem_req_t item;
    int       due;
    @(negedge clk);
    cyc++;
    if (r) begin
      mem_q.delete();
      last_due = cyc;
    end
    rsp_now = !r && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rst                = r;
    stall_D            = st;
    redirect_valid     = rd;
    redirect_pc        = rpc;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? data_of(mem_q[0].addr) : 32'h0;
    #1;
    m_req     = !r && !rd && ((mem_q.size() + avail_pc.size()) < DEPTH);
    seen_req  = bus.imem_req_valid;
    seen_addr = bus.imem_addr;
    checkOutput("imem_req_valid", {31'b0, seen_req}, {31'b0, m_req});
    if (m_req) begin
      checkOutput("imem_addr", seen_addr, m_pc);
    end
    item = '{addr: 32'h0, due: 0, stale: 1'b1};
    if (rsp_now) begin
      item = mem_q.pop_front();
    end
    m_bub = !r && !st && !rd && (avail_pc.size() == 0);
    if (r) begin
      avail_pc.delete();
      avail_data.delete();
      m_pc       = RESET_PC;
      exp_valid  = 1'b0;
      exp_instr  = 32'h0;
      exp_pcd    = 32'h0;
      know_instr = 1'b1;
      know_pcd   = 1'b1;
      m_fetch    = 32'h0;
      m_bubble   = 32'h0;
    end else begin
      if (rsp_now && !item.stale && !rd) begin
        avail_pc.push_back(item.addr);
        avail_data.push_back(data_of(item.addr));
      end
      if (m_bub) begin
        m_bubble = m_bubble + 32'd1;
      end
      if (rd) begin
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        avail_pc.delete();
        avail_data.delete();
        exp_valid  = 1'b0;
        exp_instr  = 32'h0;
        know_instr = 1'b1;
        know_pcd   = 1'b0;
        m_pc       = rpc & ~32'h3;
      end else begin
        if (!st) begin
          if (avail_pc.size() > 0) begin
            exp_valid  = 1'b1;
            exp_pcd    = avail_pc.pop_front();
            exp_instr  = avail_data.pop_front();
            know_instr = 1'b1;
            know_pcd   = 1'b1;
            m_fetch    = m_fetch + 32'd1;
          end else begin
            exp_valid  = 1'b0;
            know_instr = 1'b0;
            know_pcd   = 1'b0;
          end
        end
        if (m_req && rdy) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
    if (seen_req && rdy) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: seen_addr, due: due, stale: rd});
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    checkOutput("valid_D", {31'b0, valid_D}, {31'b0, exp_valid});
    if (know_instr) checkOutput("Instruction_D", Instruction_D, exp_instr);
    if (know_pcd)   checkOutput("PC_D", PC_D, exp_pcd);
`ifdef IFU_PERF_CNT_EN
    checkOutput("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    checkOutput("perf_bubble_cnt", perf_bubble_cnt, m_bubble);
`endif
  endtask

  initial begin
    logic        found;
    logic [31:0] first_pc;
    logic        r_r, r_st, r_rd, r_rdy;
    logic [31:0] r_pc;

    rst                = 1'b1;
    stall_D            = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;

    // Back-to-back fetch from reset with single-cycle memory
    applyStimulus(1, 0, 0, 0, 1, 1);
    checkOutput("t1_reset_valid", {31'b0, valid_D}, 32'h0);
    checkOutput("t1_reset_instr", Instruction_D, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t1_addr0", seen_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t1_addr1", seen_addr, 32'h4);
    checkOutput("t1_valid_c3", {31'b0, valid_D}, 32'h1);
    checkOutput("t1_pcd0", PC_D, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t1_addr2", seen_addr, 32'h8);
    checkOutput("t1_pcd1", PC_D, 32'h4);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t1_pcd2", PC_D, 32'h8);

    // Decode stall fills the prefetch window, then drains in order
    applyStimulus(1, 0, 0, 0, 1, 1);
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 1, 1);
    checkOutput("t2_accepts", acc_cnt, DEPTH);
    checkOutput("t2_stall_valid", {31'b0, valid_D}, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t2_release_pcd", PC_D, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 1, 2);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 1, 2);

    // Redirect with two requests in flight at latency 3
    applyStimulus(1, 0, 0, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 1, 3);
    applyStimulus(0, 0, 1, 32'h100, 1, 3);
    found    = 1'b0;
    first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 3);
      if (valid_D) begin
        found    = 1'b1;
        first_pc = PC_D;
      end
    end
    checkOutput("t3_first_pc", first_pc, 32'h100);
    applyStimulus(0, 0, 0, 0, 1, 3);
    checkOutput("t3_second_pc", PC_D, 32'h104);

    // Redirect together with a response and a stall
    applyStimulus(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 1, 32'h203, 1, 1);
    checkOutput("t4_valid", {31'b0, valid_D}, 32'h0);
    checkOutput("t4_instr", Instruction_D, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t4_req", {31'b0, seen_req}, 32'h1);
    checkOutput("t4_addr", seen_addr, 32'h200);

    // Random memory ready with varying latency
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, ($urandom_range(0, 7) == 0), 0, 0,
                    ($urandom_range(0, 1) == 1), $urandom_range(1, 4));
    end

    // Reset in the middle of a stream
    applyStimulus(1, 0, 0, 0, 1, 1);
    checkOutput("t6_valid", {31'b0, valid_D}, 32'h0);
`ifdef IFU_PERF_CNT_EN
    checkOutput("t6_fetch_cnt", perf_fetch_cnt, 32'h0);
    checkOutput("t6_bubble_cnt", perf_bubble_cnt, 32'h0);
`endif
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("t6_req", {31'b0, seen_req}, 32'h1);
    checkOutput("t6_addr", seen_addr, RESET_PC);

    // Fully randomized traffic, including PC wrap near the top of memory
    for (int i = 0; i < 3000; i++) begin
      r_r   = ($urandom_range(0, 199) == 0);
      r_rd  = ($urandom_range(0, 29) == 0);
      r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : 32'($urandom);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      applyStimulus(r_r, r_st, r_rd, r_pc, r_rdy, $urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
